// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the mem_ctrl RAM block
// Purpose: FSM state encoding, read-latency ceiling and byte-enable width helper
//          used by mem_ctrl and mem_rd_pipe.
// Optional feature macro: MEM_BYTEWR_EN (byte-enable width helper is used only then).
package mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  localparam int READ_LAT_MAX = 4;

  // Number of byte lanes in a data word.
  function automatic int be_width(input int data_w);
    return (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - fixed-latency valid/data delay line for read responses
// Purpose: delays a read-capture valid/data pair by READ_LAT register stages.
//          Valid bits clear on reset; each data stage loads only when its
//          incoming valid is set, so the output holds the last response.
// Ports:
//   i_clk    in   clock, rising edge
//   i_rst    in   asynchronous reset, active-high
//   i_valid  in   read data captured this cycle
//   i_data   in   captured read data
//   o_valid  out  response valid, one-cycle pulse per read
//   o_data   out  response data, holds when o_valid is low
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  // Latencies outside 1..READ_LAT_MAX are clamped into the supported range.
  localparam int LAT = (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX :
                       (READ_LAT < 1)            ? 1 : READ_LAT;

  logic [LAT-1:0]    r_vld;
  logic [DATA_W-1:0] r_data [LAT];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign o_valid = r_vld[LAT-1];
  assign o_data  = r_data[LAT-1];

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-port synchronous RAM with init sweep and fixed-latency reads
// Purpose: DEPTH x DATA_W storage behind a valid/ready request port. After reset,
//          or on i_clr while idle, every word is swept to INIT_VAL; requests are
//          refused during the sweep. Reads return through a READ_LAT-stage pipe.
// Optional feature macro: MEM_BYTEWR_EN - adds i_req_be for per-byte writes.
// Ports:
//   i_clk        in   clock, rising edge
//   i_rst        in   asynchronous reset, active-high
//   i_clr        in   request re-initialisation sweep (sampled in IDLE)
//   o_busy       out  init sweep in progress
//   i_req_valid  in   request present
//   o_req_ready  out  request can be accepted this cycle
//   i_req_we     in   1 = write, 0 = read
//   i_req_addr   in   word address
//   i_req_wdata  in   write data
//   i_req_be     in   byte write enables (MEM_BYTEWR_EN only)
//   o_rsp_valid  out  read data valid, one-cycle pulse per read
//   o_rsp_rdata  out  read data, holds when o_rsp_valid is low
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clr,
  output logic                        o_busy,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic                        i_req_we,
  input  logic [ADDR_W-1:0]           i_req_addr,
  input  logic [DATA_W-1:0]           i_req_wdata,
`ifdef MEM_BYTEWR_EN
  input  logic [be_width(DATA_W)-1:0] i_req_be,
`endif
  output logic                        o_rsp_valid,
  output logic [DATA_W-1:0]           o_rsp_rdata
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              w_accept;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_cnt_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    o_req_ready = 1'b0;
    case (r_state)
      INIT: begin
        o_busy = 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_clr) begin
          w_state_nxt = INIT;
        end
      end
    endcase
  end

  assign w_accept   = i_req_valid && o_req_ready;
  // One spare bit so the compare also works when DEPTH == 2**ADDR_W.
  assign w_in_range = ({1'b0, i_req_addr} < (ADDR_W+1)'(DEPTH));
  assign w_idx      = i_req_addr[IDX_W-1:0];
  assign w_cnt_idx  = r_cnt[IDX_W-1:0];
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : INIT_VAL;

  // Storage is deliberately not reset; the sweep gives it a known value.
  // Sweep and request writes are exclusive because requests are only
  // accepted in IDLE.
  always_ff @(posedge i_clk) begin
    if (r_state == INIT) begin
      r_mem[w_cnt_idx] <= INIT_VAL;
    end else if (w_accept && i_req_we && w_in_range) begin
`ifdef MEM_BYTEWR_EN
      for (int b = 0; b < be_width(DATA_W); b++) begin
        if (i_req_be[b]) begin
          r_mem[w_idx][b*8 +: 8] <= i_req_wdata[b*8 +: 8];
        end
      end
`else
      r_mem[w_idx] <= i_req_wdata;
`endif
    end
  end

  // Read data is captured at the accept edge, so a clr in the same cycle
  // still sees pre-clear contents.
  mem_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_accept && !i_req_we),
    .i_data  (w_rd_data),
    .o_valid (o_rsp_valid),
    .o_data  (o_rsp_rdata)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

`ifdef MEM_BYTEWR_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int LAT   = 3;
  localparam logic [DW-1:0] IV = DW'(8'h3C);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          busy;
  logic          ready;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
`ifdef MEM_BYTEWR_EN
  logic [DW/8-1:0] req_be = '1;
`endif
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  int n_pass  = 0;
  int n_total = 0;

  mem_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .READ_LAT (LAT),
    .INIT_VAL (IV)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr       (clr),
    .o_busy      (busy),
    .i_req_valid (req_valid),
    .o_req_ready (ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
`ifdef MEM_BYTEWR_EN
    .i_req_be    (req_be),
`endif
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; the request is accepted at the following posedge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
`ifdef MEM_BYTEWR_EN
    req_be = '1;
`endif
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

`ifdef MEM_BYTEWR_EN
  task automatic wr_be(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_be = '1;
  endtask
`endif

  // Read with LAT=3: response visible at the third negedge after issue.
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_early0"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_early1"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, 32'(rsp_rdata), 32'(exp));
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_hold"}, 32'(rsp_rdata), 32'(exp));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy_ready", 32'({busy, ready}), 32'b10);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);

    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("sweep_busy_%0d", i), 32'({busy, ready}), 32'b10);
    end
    @(negedge clk);
    chk("sweep_done_ready", 32'({busy, ready}), 32'b01);

    rd_chk("rd_init5", 4'd5, IV);

    wr(4'd3, DW'(8'hA5));
    rd_chk("raw3", 4'd3, DW'(8'hA5));

    wr(4'd0, DW'(8'h11));
    wr(4'd1, DW'(8'h22));
    wr(4'd2, DW'(8'h33));
    wr(4'd11, DW'(8'h99));

    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
    @(negedge clk); req_addr = 4'd1;
    @(negedge clk); req_addr = 4'd2;
    @(negedge clk); req_valid = 1'b0;
    chk("b2b_v0", 32'(rsp_valid), 32'd1);
    chk("b2b_d0", 32'(rsp_rdata), 32'h11);
    @(negedge clk);
    chk("b2b_v1", 32'(rsp_valid), 32'd1);
    chk("b2b_d1", 32'(rsp_rdata), 32'h22);
    @(negedge clk);
    chk("b2b_v2", 32'(rsp_valid), 32'd1);
    chk("b2b_d2", 32'(rsp_rdata), 32'h33);
    @(negedge clk);
    chk("b2b_end", 32'(rsp_valid), 32'd0);

    rd_chk("pre_clr11", 4'd11, DW'(8'h99));

    clr = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    @(negedge clk);
    clr = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("clr_busy_%0d", i), 32'({busy, ready}), 32'b10);
      chk($sformatf("clr_rsp_v_%0d", i), 32'(rsp_valid), 32'(i == 2));
      if (i == 2) chk("clr_rsp_data", 32'(rsp_rdata), 32'hA5);
    end
    @(negedge clk);
    chk("clr_done_ready", 32'({busy, ready}), 32'b01);

    rd_chk("post_clr3", 4'd3, IV);
    rd_chk("post_clr11", 4'd11, IV);
    rd_chk("post_clr0", 4'd0, IV);

    wr(4'd14, DW'(8'hFF));
    rd_chk("oor14", 4'd14, IV);
    rd_chk("oor_alias2", 4'd2, IV);
    wr(4'd11, DW'(8'h77));
    rd_chk("last11", 4'd11, DW'(8'h77));

`ifdef MEM_BYTEWR_EN
    wr_be(4'd7, 16'hBEEF, 2'b11);
    wr_be(4'd7, 16'h1234, 2'b01);
    rd_chk("be_lo", 4'd7, 16'hBE34);
    wr_be(4'd7, 16'hFFFF, 2'b00);
    rd_chk("be_none", 4'd7, 16'hBE34);
    wr_be(4'd7, 16'hA1C2, 2'b10);
    rd_chk("be_hi", 4'd7, 16'hA134);
`endif

    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd11;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_busy_ready", 32'({busy, ready}), 32'b10);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("resweep_busy_%0d", i), 32'({busy, ready}), 32'b10);
      chk($sformatf("resweep_drop_%0d", i), 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    chk("resweep_ready", 32'({busy, ready}), 32'b01);
    rd_chk("resweep11", 4'd11, IV);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Parametrised single-port synchronous RAM with a valid/ready request interface and a fixed-latency read-response pipeline. After reset, and on demand via a clear request, it sweeps every location to a known value; storage itself is never reset. It replaces the fixed 8-bit, 256-entry negedge memory in the processor datapath, and the CPU load/store unit is its single requester.

Parameters:
DATA_W, 8, data word width in bits (must be a multiple of 8 when MEM_BYTEWR_EN is defined)
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
READ_LAT, 1, cycles from read acceptance to rsp_valid; legal range 1..4
INIT_VAL, 0, value written to every word during an init sweep

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
clr  in  1  request a re-initialisation sweep; sampled only in IDLE
busy  out  1  high while an init sweep is in progress
req_valid  in  1  request present
req_ready  out  1  request can be accepted this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte write enables (present only with MEM_BYTEWR_EN)
rsp_valid  out  1  read data valid; single-cycle pulse per read
rsp_rdata  out  DATA_W  read data

Behaviour:
- Reset values: state=INIT, sweep counter=0, busy=1, req_ready=0, rsp_valid=0, rsp_rdata=0, all pipeline valid bits=0.
- FSM states and transitions:
  - INIT: writes INIT_VAL to address cnt each cycle and increments cnt. When cnt==DEPTH-1, the write is performed, the next state is IDLE and cnt returns to 0. No wrap past DEPTH-1.
  - IDLE: clr=1 moves the FSM to INIT on the next cycle.
- Outputs derived from state (registered state, combinational decode): busy = (state==INIT); req_ready = (state==IDLE). After a reset the sweep takes exactly DEPTH cycles, and req_ready rises on the cycle after the last sweep write.
- Accept: a request is accepted on the rising edge where req_valid && req_ready.
- Write: the memory updates at the accept edge. No response is produced.
- Read: memory[addr] is sampled at the accept edge and delivered through READ_LAT register stages. rsp_valid goes high exactly READ_LAT cycles after the accept edge for one cycle, then returns to 0. rsp_rdata holds its last value when rsp_valid=0.
- Back-to-back reads: one per cycle, responses in order. There is no response backpressure.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- clr and a request in the same IDLE cycle: the request is accepted and executes first. A read returns pre-clear data.
- In-flight reads when INIT starts: they complete normally with their captured data. Pipeline stages are not flushed by clr.
- Out-of-range address (addr >= DEPTH): writes are ignored and reads return INIT_VAL; rsp_valid timing is unchanged.
- Reset asserted mid-operation: everything returns to reset values immediately, and in-flight responses are dropped. After rst deasserts, a full sweep runs again.

Optional Feature:
MEM_BYTEWR_EN
- Defined: the req_be port exists. A write updates only the bytes whose req_be bit is 1; req_be=0 is a legal no-op write. Init sweeps write all bytes.
- Undefined: the req_be port is absent, and every write updates the full word.

Decomposition:
- Package mem_pkg holds:
  - state enum {INIT, IDLE}
  - READ_LAT_MAX=4 constant
  - a width helper for the byte-enable count
- Sub-module mem_rd_pipe: a READ_LAT-deep valid/data delay line with async reset on the valid bits, instantiated once. The FSM, sweep counter and storage array stay in mem_ctrl.

Test Plan:
- Reset with DEPTH=16: busy=1 for 16 cycles, req_ready=0 throughout, req_ready=1 on cycle 17; a read of address 5 returns 0x00.
- Write 0xA5 to address 3, then read address 3 on the next cycle with READ_LAT=3: rsp_valid pulses exactly 3 cycles after the read accept, rsp_rdata=0xA5.
- Reads of addresses 0,1,2 on consecutive cycles after writing 0x11/0x22/0x33: three consecutive rsp_valid pulses carrying 0x11, 0x22, 0x33 in order.
- clr asserted together with a read of address 3 (contents 0xA5): the read returns 0xA5, busy goes high the next cycle for DEPTH cycles, and a subsequent read of address 3 returns INIT_VAL.
- DEPTH=12, ADDR_W=4: a write of 0xFF to address 14 leaves no effect; a read of address 14 gives rsp_valid with INIT_VAL; rst pulsed mid-stream drops the pending rsp_valid and the sweep restarts.
- MEM_BYTEWR_EN, DATA_W=16: write 0xBEEF with be=2'b11, then 0x1234 with be=2'b01, to address 7; the read returns 0xBE34.
